// File: rtl/pulse_threshold_detector_pkg.sv
// Shared types for the pulse threshold detector: FSM state encoding and
// the report record at the default widths.
package pulse_detector_pkg;

  localparam int PD_DATA_W = 16;
  localparam int PD_DUR_W  = 16;
  localparam int PD_TS_W   = 48;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRACKING = 2'd1,
    ST_WAIT_LOW = 2'd2
  } pd_state_e;

  typedef struct packed {
    logic [PD_TS_W-1:0]   start_time;
    logic [PD_DUR_W-1:0]  duration;
    logic [PD_DATA_W-1:0] peak;
    logic                 truncated;
  } pulse_report_t;

endpackage

// File: rtl/pulse_threshold_detector_if.sv
// Sample stream, threshold configuration and pulse report bundle.
// master drives samples/config and consumes reports; slave is the detector.
interface pulse_threshold_detector_if #(
  parameter int DATA_WIDTH      = 16,
  parameter int DURATION_WIDTH  = 16,
  parameter int TIMESTAMP_WIDTH = 48
);
  logic                       input_valid;
  logic [DATA_WIDTH-1:0]      input_data;
  logic [DATA_WIDTH-1:0]      threshold_high;
  logic [DATA_WIDTH-1:0]      threshold_low;
  logic [DURATION_WIDTH-1:0]  min_duration;
  logic                       pulse_valid;
  logic [TIMESTAMP_WIDTH-1:0] pulse_start_time;
  logic [DURATION_WIDTH-1:0]  pulse_duration;
  logic [DATA_WIDTH-1:0]      pulse_peak;
  logic                       pulse_truncated;

  modport master (
    output input_valid, input_data, threshold_high, threshold_low, min_duration,
    input  pulse_valid, pulse_start_time, pulse_duration, pulse_peak, pulse_truncated
  );

  modport slave (
    input  input_valid, input_data, threshold_high, threshold_low, min_duration,
    output pulse_valid, pulse_start_time, pulse_duration, pulse_peak, pulse_truncated
  );
endinterface

// File: rtl/pulse_threshold_detector.sv
// Two-level hysteresis pulse detector. Starts a pulse at >= high, keeps it
// while >= the low level latched at pulse start, and emits one registered
// report per qualified pulse. Cycles without a valid sample are inert.
module pulse_threshold_detector
  import pulse_detector_pkg::*;
#(
  parameter int DATA_WIDTH      = PD_DATA_W,
  parameter int DURATION_WIDTH  = PD_DUR_W,
  parameter int TIMESTAMP_WIDTH = PD_TS_W
) (
  input  logic clk_i,
  input  logic rst_i,
  pulse_threshold_detector_if.slave pd_if
);

  localparam logic [DURATION_WIDTH-1:0] DUR_MAX = '1;

  pd_state_e                  state_q;
  logic [TIMESTAMP_WIDTH-1:0] idx_q, idx_d;
  logic [TIMESTAMP_WIDTH-1:0] start_q;
  logic [DURATION_WIDTH-1:0]  dur_q, dur_inc;
  logic [DATA_WIDTH-1:0]      peak_q, peak_max;
  logic [DATA_WIDTH-1:0]      low_q;
  logic [DURATION_WIDTH-1:0]  min_q;

  logic                       rpt_valid_q;
  logic [TIMESTAMP_WIDTH-1:0] rpt_start_q;
  logic [DURATION_WIDTH-1:0]  rpt_dur_q;
  logic [DATA_WIDTH-1:0]      rpt_peak_q;
  logic                       rpt_trunc_q;

  assign idx_d    = idx_q + TIMESTAMP_WIDTH'(1);
  assign dur_inc  = dur_q + DURATION_WIDTH'(1);
  assign peak_max = (pd_if.input_data > peak_q) ? pd_if.input_data : peak_q;

  // Sample index: counts valid samples, wraps naturally at full width.
  always_ff @(posedge clk_i) begin
    if (rst_i)                  idx_q <= '0;
    else if (pd_if.input_valid) idx_q <= idx_d;
  end

  // Pulse FSM with registered report; the strobe lasts one cycle, fields hold.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      start_q     <= '0;
      dur_q       <= '0;
      peak_q      <= '0;
      low_q       <= '0;
      min_q       <= '0;
      rpt_valid_q <= 1'b0;
      rpt_start_q <= '0;
      rpt_dur_q   <= '0;
      rpt_peak_q  <= '0;
      rpt_trunc_q <= 1'b0;
    end else begin
      rpt_valid_q <= 1'b0;
      if (pd_if.input_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (pd_if.input_data >= pd_if.threshold_high) begin
              state_q <= ST_TRACKING;
              start_q <= idx_q;
              dur_q   <= DURATION_WIDTH'(1);
              peak_q  <= pd_if.input_data;
              // Low level and minimum length are frozen for the whole pulse.
              low_q   <= pd_if.threshold_low;
              min_q   <= pd_if.min_duration;
            end
          end
          ST_TRACKING: begin
            if (pd_if.input_data >= low_q) begin
              dur_q  <= dur_inc;
              peak_q <= peak_max;
              if (dur_inc == DUR_MAX) begin
                rpt_valid_q <= 1'b1;
                rpt_start_q <= start_q;
                rpt_dur_q   <= dur_inc;
                rpt_peak_q  <= peak_max;
                rpt_trunc_q <= 1'b1;
                state_q     <= ST_WAIT_LOW;
              end
            end else begin
              // Ending sample is neither counted nor re-tested against high.
              if (dur_q >= min_q) begin
                rpt_valid_q <= 1'b1;
                rpt_start_q <= start_q;
                rpt_dur_q   <= dur_q;
                rpt_peak_q  <= peak_q;
                rpt_trunc_q <= 1'b0;
              end
              state_q <= ST_IDLE;
            end
          end
          ST_WAIT_LOW: begin
            if (pd_if.input_data < pd_if.threshold_low) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign pd_if.pulse_valid      = rpt_valid_q;
  assign pd_if.pulse_start_time = rpt_start_q;
  assign pd_if.pulse_duration   = rpt_dur_q;
  assign pd_if.pulse_peak       = rpt_peak_q;
  assign pd_if.pulse_truncated  = rpt_trunc_q;

endmodule

// File: tb/tb_pulse_threshold_detector.sv
// Bench for pulse_threshold_detector: two instances (default widths, and
// duration 8 / timestamp 4 bits) share one stimulus stream. Directed table,
// hand sequences and a randomized run are checked against a sample-level
// reference model every cycle.
module tb_pulse_threshold_detector;
  import pulse_detector_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic in_v = 1'b0;
  int   in_d = 0;
  int   thr_hi = 1000, thr_lo = 800, thr_mn = 4;

  pulse_threshold_detector_if #(.DATA_WIDTH(16), .DURATION_WIDTH(16), .TIMESTAMP_WIDTH(48)) if0 ();
  pulse_threshold_detector_if #(.DATA_WIDTH(16), .DURATION_WIDTH(8),  .TIMESTAMP_WIDTH(4))  if1 ();

  assign if0.input_valid    = in_v;
  assign if0.input_data     = in_d[15:0];
  assign if0.threshold_high = thr_hi[15:0];
  assign if0.threshold_low  = thr_lo[15:0];
  assign if0.min_duration   = thr_mn[15:0];
  assign if1.input_valid    = in_v;
  assign if1.input_data     = in_d[15:0];
  assign if1.threshold_high = thr_hi[15:0];
  assign if1.threshold_low  = thr_lo[15:0];
  assign if1.min_duration   = thr_mn[7:0];

  pulse_threshold_detector #(.DATA_WIDTH(16), .DURATION_WIDTH(16), .TIMESTAMP_WIDTH(48)) dut0 (
    .clk_i(clk), .rst_i(rst), .pd_if(if0));
  pulse_threshold_detector #(.DATA_WIDTH(16), .DURATION_WIDTH(8), .TIMESTAMP_WIDTH(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .pd_if(if1));

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference model: one entry per instance, walks the sample stream with
  // plain integers; index wraps by modulo, duration limit is 2**W-1.
  int     m_mode [2];            // 0 idle, 1 in pulse, 2 held high after truncation
  longint m_idx [2], m_start [2];
  int     m_dur [2], m_peak [2], m_low [2], m_min [2];
  pulse_report_t m_rpt [2];
  bit     m_rv [2];
  int     dlim [2];
  longint tmod [2];

  task automatic model_step(input int k, input bit r, input bit v, input int d);
    m_rv[k] = 1'b0;
    if (r) begin
      m_mode[k] = 0; m_idx[k] = 0; m_rpt[k] = '0;
      return;
    end
    if (!v) return;
    if (m_mode[k] == 0) begin
      if (d >= thr_hi) begin
        m_mode[k] = 1; m_start[k] = m_idx[k]; m_dur[k] = 1; m_peak[k] = d;
        m_low[k] = thr_lo; m_min[k] = thr_mn;
      end
    end else if (m_mode[k] == 1) begin
      if (d >= m_low[k]) begin
        m_dur[k]++;
        if (d > m_peak[k]) m_peak[k] = d;
        if (m_dur[k] == dlim[k]) begin
          m_rv[k] = 1'b1;
          m_rpt[k] = '{start_time: m_start[k], duration: m_dur[k], peak: m_peak[k], truncated: 1'b1};
          m_mode[k] = 2;
        end
      end else begin
        if (m_dur[k] >= m_min[k]) begin
          m_rv[k] = 1'b1;
          m_rpt[k] = '{start_time: m_start[k], duration: m_dur[k], peak: m_peak[k], truncated: 1'b0};
        end
        m_mode[k] = 0;
      end
    end else begin
      if (d < thr_lo) m_mode[k] = 0;
    end
    m_idx[k] = (m_idx[k] + 1) % tmod[k];
  endtask

  task automatic check_model();
    cmp("d0.valid", if0.pulse_valid,      m_rv[0]);
    cmp("d0.start", if0.pulse_start_time, m_rpt[0].start_time);
    cmp("d0.dur",   if0.pulse_duration,   m_rpt[0].duration);
    cmp("d0.peak",  if0.pulse_peak,       m_rpt[0].peak);
    cmp("d0.trunc", if0.pulse_truncated,  m_rpt[0].truncated);
    cmp("d1.valid", if1.pulse_valid,      m_rv[1]);
    cmp("d1.start", if1.pulse_start_time, m_rpt[1].start_time);
    cmp("d1.dur",   if1.pulse_duration,   m_rpt[1].duration);
    cmp("d1.peak",  if1.pulse_peak,       m_rpt[1].peak);
    cmp("d1.trunc", if1.pulse_truncated,  m_rpt[1].truncated);
  endtask

  // One clock: drive after a falling edge, edge, then sample on the next fall.
  task automatic step(input bit r, input bit v, input int d);
    rst = r; in_v = v; in_d = d;
    model_step(0, r, v, d);
    model_step(1, r, v, d);
    @(posedge clk);
    @(negedge clk);
    check_model();
    rst = 1'b0; in_v = 1'b0;
  endtask

  task automatic gap();
    int n;
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom_range(0, 3000));
  endtask

  task automatic sample(input int d, input bit with_gap);
    if (with_gap) gap();
    step(1'b0, 1'b1, d);
  endtask

  typedef struct {
    bit     r;
    bit     v;
    int     d;
    bit     ev;
    longint es;
    int     ed;
    int     ep;
    bit     et;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input int d, input bit ev,
                     input longint es, input int ed, input int ep, input bit et);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.ev = ev; x.es = es; x.ed = ed; x.ep = ep; x.et = et;
    tbl.push_back(x);
  endtask

  task automatic replay_s1(input bit g);
    int s[8] = '{0, 0, 1200, 1500, 1100, 900, 850, 700};
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) sample(s[i], g);
    cmp("s1.valid", if0.pulse_valid, 1);
    cmp("s1.start", if0.pulse_start_time, 2);
    cmp("s1.dur",   if0.pulse_duration, 5);
    cmp("s1.peak",  if0.pulse_peak, 1500);
  endtask

  task automatic replay_s3(input bit g);
    step(1'b1, 1'b0, 0);
    sample(1200, g);
    for (int i = 0; i < 50; i++) begin
      sample(900, g);
      cmp("s3.hold", if0.pulse_valid, 0);
    end
    sample(799, g);
    cmp("s3.valid", if0.pulse_valid, 1);
    cmp("s3.dur",   if0.pulse_duration, 51);
    cmp("s3.peak",  if0.pulse_peak, 1200);
    cmp("s3.trunc", if0.pulse_truncated, 0);
  endtask

  initial begin
    dlim[0] = 65535; dlim[1] = 255;
    tmod[0] = 64'd1 << 48; tmod[1] = 16;
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_idx[k] = 0; m_rpt[k] = '0; m_rv[k] = 1'b0;
    end
    @(negedge clk);

    // Directed table: scenarios 1 and 2 at high=1000 low=800 min=4.
    add(1, 0, 0,    0, 0, 0, 0, 0);
    add(0, 1, 0,    0, 0, 0, 0, 0);
    add(0, 1, 0,    0, 0, 0, 0, 0);
    add(0, 1, 1200, 0, 0, 0, 0, 0);
    add(0, 1, 1500, 0, 0, 0, 0, 0);
    add(0, 1, 1100, 0, 0, 0, 0, 0);
    add(0, 1, 900,  0, 0, 0, 0, 0);
    add(0, 1, 850,  0, 0, 0, 0, 0);
    add(0, 1, 700,  1, 2, 5, 1500, 0);
    add(0, 1, 0,    0, 0, 0, 0, 0);
    add(1, 0, 0,    0, 0, 0, 0, 0);
    add(0, 1, 1200, 0, 0, 0, 0, 0);
    add(0, 1, 1300, 0, 0, 0, 0, 0);
    add(0, 1, 500,  0, 0, 0, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0);
    add(0, 1, 1000, 0, 0, 0, 0, 0);
    add(0, 1, 0,    1, 3, 4, 1000, 0);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].v, tbl[i].d);
      cmp("tbl.valid", if0.pulse_valid, tbl[i].ev);
      if (tbl[i].ev || tbl[i].r) begin
        cmp("tbl.start", if0.pulse_start_time, tbl[i].es);
        cmp("tbl.dur",   if0.pulse_duration,   tbl[i].ed);
        cmp("tbl.peak",  if0.pulse_peak,       tbl[i].ep);
        cmp("tbl.trunc", if0.pulse_truncated,  tbl[i].et);
      end
    end

    // Hysteresis.
    replay_s3(1'b0);

    // Truncation on the 8-bit duration instance.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 300; i++) begin
      sample(2000, 1'b0);
      if (i == 254) begin
        cmp("tr.valid", if1.pulse_valid, 1);
        cmp("tr.dur",   if1.pulse_duration, 255);
        cmp("tr.trunc", if1.pulse_truncated, 1);
        cmp("tr.start", if1.pulse_start_time, 0);
      end else begin
        cmp("tr.quiet", if1.pulse_valid, 0);
      end
    end
    sample(0, 1'b0);
    cmp("tr.d1quiet", if1.pulse_valid, 0);
    cmp("tr.d0dur",   if0.pulse_duration, 300);
    for (int i = 0; i < 4; i++) sample(1200, 1'b0);
    sample(0, 1'b0);
    cmp("tr.d1new",   if1.pulse_valid, 1);
    cmp("tr.d1start", if1.pulse_start_time, 301 % 16);
    cmp("tr.d1trunc", if1.pulse_truncated, 0);
    cmp("tr.d0start", if0.pulse_start_time, 301);

    // Reset mid-pulse for 10 cycles, then index restarts at 0.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) sample(1500, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1500);
      cmp("rst.quiet", if0.pulse_valid, 0);
    end
    sample(0, 1'b0);
    cmp("rst.noreport", if0.pulse_valid, 0);
    for (int i = 0; i < 4; i++) sample(1200, 1'b0);
    sample(0, 1'b0);
    cmp("rst.start", if0.pulse_start_time, 1);

    // Threshold_low / Min_duration changed mid-pulse are ignored.
    step(1'b1, 1'b0, 0);
    thr_mn = 2;
    sample(1200, 1'b0);
    sample(1200, 1'b0);
    thr_lo = 100; thr_mn = 9;
    sample(500, 1'b0);
    cmp("lat.valid", if0.pulse_valid, 1);
    cmp("lat.dur",   if0.pulse_duration, 2);
    thr_lo = 800; thr_mn = 4;

    // Replays with random idle gaps.
    replay_s1(1'b1);
    replay_s3(1'b1);

    // Randomized segments: thresholds (including low > high), min 0..6,
    // long plateaus for truncation, rare resets; index wraps on instance 1.
    for (int seg = 0; seg < 300; seg++) begin
      int lvl, len;
      if ($urandom_range(0, 99) < 8) begin
        thr_hi = $urandom_range(500, 3000);
        thr_lo = $urandom_range(300, 3000);
        thr_mn = $urandom_range(0, 6);
      end
      lvl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 400) : $urandom_range(0, 3500);
      len = ($urandom_range(0, 49) == 0) ? $urandom_range(250, 320) : $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 999) < 3) step(1'b1, 1'b0, 0);
        else step(1'b0, $urandom_range(0, 9) < 7, lvl + $urandom_range(0, 200));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_threshold_detector.md
Name: pulse_threshold_detector

Overview:
Consumes the averaged magnitude stream from filter_moving_avg and detects pulses using a two-level hysteresis threshold. For each qualified pulse it emits a single report containing start time (sample index), duration in samples, peak magnitude and a truncation flag. The reports feed the downstream pulse reporting and buffering logic.

Parameters:
DATA_WIDTH, 16, width of the input magnitude and of the thresholds.
DURATION_WIDTH, 16, width of the duration counter; maximum duration is 2**DURATION_WIDTH-1.
TIMESTAMP_WIDTH, 48, width of the free-running sample index counter.

Ports:
Clk  input  1  clock.
Rst  input  1  synchronous reset, active-high.
Input_valid  input  1  one magnitude sample this cycle.
Input_data  input  DATA_WIDTH  unsigned averaged magnitude.
Threshold_high  input  DATA_WIDTH  pulse-start threshold; quasi-static.
Threshold_low  input  DATA_WIDTH  pulse-end threshold; quasi-static.
Min_duration  input  DURATION_WIDTH  minimum duration of a reported pulse, in samples.
Pulse_valid  output  1  one-cycle strobe carrying a report.
Pulse_start_time  output  TIMESTAMP_WIDTH  sample index of the first sample of the pulse.
Pulse_duration  output  DURATION_WIDTH  pulse length in samples.
Pulse_peak  output  DATA_WIDTH  maximum Input_data seen within the pulse.
Pulse_truncated  output  1  pulse reached the maximum duration.

Behaviour:
- Clock and reset: one clock, Clk. Rst is synchronous and active-high.
- Sample index counter:
  - Resets to 0; increments by 1 on every Input_valid.
  - Wraps modulo 2**TIMESTAMP_WIDTH.
  - The index of a sample is the counter value before its increment, so the first sample after reset has index 0.
- Cycles with Input_valid=0 change no state. Gaps between samples of any length are transparent.
- FSM states are IDLE, TRACKING and WAIT_LOW. All transitions happen only on valid samples.
- IDLE:
  - If data >= Threshold_high: go to TRACKING, start_time=index, duration=1, peak=data.
  - Threshold_low and Min_duration are latched at this point. Changes during a pulse are ignored.
- TRACKING, sample with data >= low_latched:
  - duration++, peak=max(peak,data).
  - If the new duration equals 2**DURATION_WIDTH-1: emit a report with truncated=1 and go to WAIT_LOW.
- TRACKING, sample with data < low_latched:
  - The ending sample is not counted.
  - If duration >= min_latched: emit a report with truncated=0.
  - In either case go to IDLE. The ending sample is not evaluated against Threshold_high in the same cycle.
- WAIT_LOW: a sample with data < Threshold_low returns to IDLE. No report is produced.
- Report timing:
  - Pulse_valid is asserted exactly one cycle after the Clk edge on which the deciding sample is presented. It is high for one cycle.
  - Report fields are registered and hold their values until the next report.
- Reset values: Pulse_valid=0 and all report fields 0. Reset also forces FSM=IDLE and counter=0.
- Reset mid-pulse: the in-progress pulse is discarded and no report is emitted.
- Threshold_low > Threshold_high is legal. A pulse then ends on the first following sample below low.
- Min_duration=0 or 1: every detected pulse is reported.
- Comparisons are unsigned at full width. No arithmetic overflow is possible: duration saturates via truncation and peak is a compare-select.

Decomposition:
- Package pulse_detector_pkg:
  - enum for the FSM state;
  - packed struct pulse_report_t {start_time, duration, peak, truncated}, parameterised via package localparams matching the defaults.
- Single module, no sub-module. The timestamp counter is a few lines and stays inline.

Test Plan:
Common settings: high=1000, low=800, min=4, unless stated.
1. Samples 0,0,1200,1500,1100,900,850,700 -> one report one cycle after the 700 sample: start=2, duration=5, peak=1500, truncated=0.
2. Samples 1200,1300,500 (short glitch) -> no report. Then 1000,1000,1000,1000,0 -> report: start=3, duration=4, peak=1000.
3. Hysteresis: 1200 followed by 50 samples of 900 then 799 -> report: duration=51, peak=1200. The 900 samples must not end the pulse.
4. Truncation with DURATION_WIDTH=8: 300 samples of 2000 -> report after the 255th sample: duration=255, truncated=1. No further report while the level stays at 2000. Then 0 followed by 1200x4 and 0 -> new report with start equal to the index of that 1200.
5. Rst asserted for 10 cycles mid-pulse -> no report; the next sample has index 0. Threshold_low changed mid-pulse -> ignored for that pulse.
6. Replay scenarios 1-3 with 0-5 random idle cycles between samples -> identical reports. Also check the counter wrap with TIMESTAMP_WIDTH=4.
